skolem_lut_engine: RTL and testbench
====================================

# skolem_lut_engine

Programmable, streaming evaluator for Skolem-function vectors. It replaces per-benchmark combinational netlists that hard-wire NY outputs over NX inputs. Each output is held as a 2^NX-bit truth table loaded at run time, and input vectors are evaluated through a valid/ready stream with one registered output stage. It sits between the benchmark stimulus source and the specification checker in the synthesis-validation flow.

## Interface
- NX, default 5, number of universally quantified inputs (x vector width), 1..8
- NY, default 2, number of Skolem outputs (y vector width), 1..16
- CW, default 16, width of the evaluation counter
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  write one truth table
- cfg_idx  in  max(1,$clog2(NY))  output index being written
- cfg_data  in  2^NX  truth table; bit k = value of y[cfg_idx] for x==k
- cfg_done  in  1  tables complete; enter RUN
- in_valid  in  1  input vector valid
- in_ready  out  1  engine can accept
- in_x  in  NX  input vector, in_x[0] = i0 (LSB of table index)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_x  out  NX  echo of evaluated input
- out_y  out  NY  out_y[j] = table_j[out_x]
- eval_cnt  out  CW  completed evaluations (see Configuration)
- run  out  1  state == RUN

## Operation
- States: LOAD (reset state), RUN.
- LOAD: in_ready=0. cfg_we writes table[cfg_idx] <= cfg_data. cfg_idx >= NY is ignored. cfg_done moves to RUN next cycle. cfg_we and cfg_done in the same cycle: write applied, then RUN.
- RUN: in_ready = !out_valid || out_ready (combinational). Accept when in_valid && in_ready; out_x/out_y are loaded next edge and out_valid is set.
- out_valid clears when out_ready && !(new accept). Output data stays stable while out_valid && !out_ready.
- cfg_we in RUN: table written, state -> LOAD next cycle. An input accepted in the same cycle is evaluated with the old table. A held output remains valid until consumed, even in LOAD.
- cfg_done in RUN: no effect.
- Tables are not cleared by cfg_done. Reset clears all tables to 0.

## Timing
- Reset values: state=LOAD, out_valid=0, out_x=0, out_y=0, eval_cnt=0, run=0, in_ready=0, all tables 0.
- Latency: accept at edge N -> out_valid at N+1.
- Throughput: 1 vector/cycle with out_ready held high.
- LOAD->RUN: cfg_done at edge N -> run=1 and in_ready may be 1 after edge N.
- eval_cnt increments on each out_valid && out_ready handshake, wraps 2^CW-1 -> 0.
- Reset asserted mid-stream: all state cleared immediately, and in-flight output is lost.

## Configuration
- SKOLEM_EVAL_CNT_EN defined: eval_cnt is implemented as described.
- SKOLEM_EVAL_CNT_EN undefined: eval_cnt is tied to 0 and no counter flops are synthesised. All other behaviour is identical.

## Test plan
- Reset, then in_valid=1 with no cfg_done -> in_ready=0, out_valid stays 0, run=0.
- NX=5, NY=2. Load table0=32'hFFFF0000, table1=32'hAAAAAAAA, then cfg_done. Send x=5'b10001 -> out_y=2'b11 one cycle later. Send x=5'b00010 -> out_y=2'b00.
- Back-to-back stream of 32 vectors x=0..31 with out_ready=1 -> 32 results with no bubbles, out_y matches tables, and eval_cnt=32 (macro defined) or 0 (undefined).
- Hold out_ready=0 with an output pending, in_valid=1 -> in_ready=0 and out_x/out_y stable. Release -> pending output is consumed and the next vector is accepted in the same cycle.
- In RUN, cfg_we (idx 0, data 0) with a vector x=5'b10000 accepted in the same cycle -> result y0=1 (old table), run=0 next cycle. cfg_done, then resend -> y0=0.
- CW=4, 17 handshakes -> eval_cnt=1 (wrap). Assert rst_n=0 while out_valid=1 -> out_valid=0 and eval_cnt=0 immediately.

Source files
------------

// File: rtl/skolem_lut_engine.sv
`default_nettype none
// ============================================================================
// Module      : skolem_lut_engine
// Description : Run-time programmable Skolem-function evaluator. Each of the NY
//               outputs is a 2^NX-bit truth table; input vectors stream in over
//               valid/ready and results leave through one registered stage.
//               Optional feature macro: SKOLEM_EVAL_CNT_EN (evaluation counter).
// Revision    : 1.0 - initial release
// ============================================================================
module skolem_lut_engine #(
    parameter int NX = 5,
    parameter int NY = 2,
    parameter int CW = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                cfg_we,
    input  logic [((NY > 1) ? $clog2(NY) : 1)-1:0] cfg_idx,
    input  logic [(1 << NX)-1:0]                cfg_data,
    input  logic                                cfg_done,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NX-1:0]                       in_x,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NX-1:0]                       out_x,
    output logic [NY-1:0]                       out_y,
    output logic [CW-1:0]                       eval_cnt,
    output logic                                run
);

    localparam int c_TW = 1 << NX;
    localparam int c_IW = (NY > 1) ? $clog2(NY) : 1;

    typedef enum logic [0:0] {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_out_valid;
    logic [NX-1:0]     r_out_x;
    logic [NY-1:0]     r_out_y;
    logic [NY-1:0]     w_lookup;
    logic              w_accept;
    logic              w_in_ready;
    logic              w_run;
    logic [c_TW-1:0]   r_table [NY];

    // State register; LOAD after reset so nothing is evaluated before tables exist
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake decode; a table write while running drops back to LOAD
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_run        = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (cfg_done) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_run      = 1'b1;
                w_in_ready = !r_out_valid || out_ready;
                if (cfg_we) begin
                    w_next_state = S_LOAD;
                end
            end
            default: begin
                w_next_state = S_LOAD;
            end
        endcase
    end

    assign w_accept = in_valid && w_in_ready;

    // One truth table per output; indices with no matching table are dropped
    for (genvar j = 0; j < NY; j++) begin : g_table
        // Table write port, reachable in either state
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_table[j] <= '0;
            end else if (cfg_we && (cfg_idx == c_IW'(j))) begin
                r_table[j] <= cfg_data;
            end
        end

        // Lookup reads the registered table, so a same-cycle write is not seen
        assign w_lookup[j] = r_table[j][in_x];
    end

    // Output stage: load on accept, drop valid once consumed without a refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_x     <= in_x;
            r_out_y     <= w_lookup;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef SKOLEM_EVAL_CNT_EN
    logic [CW-1:0] r_eval_cnt;

    // Count completed output handshakes; wraps naturally at 2^CW
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eval_cnt <= '0;
        end else if (r_out_valid && out_ready) begin
            r_eval_cnt <= r_eval_cnt + 1'b1;
        end
    end

    assign eval_cnt = r_eval_cnt;
`else
    assign eval_cnt = '0;
`endif

    assign in_ready  = w_in_ready;
    assign run       = w_run;
    assign out_valid = r_out_valid;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;

endmodule
`default_nettype wire

// File: tb/tb_skolem_lut_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_skolem_lut_engine
// Description : Directed self-checking bench for skolem_lut_engine. A second
//               instance with a 4-bit counter shares all stimulus so counter
//               wrap can be observed alongside the default build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skolem_lut_engine;

    localparam int NX = 5;
    localparam int NY = 2;
    localparam int CW = 16;
    localparam int CWS = 4;

`ifdef SKOLEM_EVAL_CNT_EN
    localparam bit c_CNT_EN = 1'b1;
`else
    localparam bit c_CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_we;
    logic [0:0]        cfg_idx;
    logic [31:0]       cfg_data;
    logic              cfg_done;
    logic              in_valid;
    logic [NX-1:0]     in_x;
    logic              out_ready;

    logic              in_ready;
    logic              out_valid;
    logic [NX-1:0]     out_x;
    logic [NY-1:0]     out_y;
    logic [CW-1:0]     eval_cnt;
    logic              run;

    logic              s_in_ready;
    logic              s_out_valid;
    logic [NX-1:0]     s_out_x;
    logic [NY-1:0]     s_out_y;
    logic [CWS-1:0]    s_eval_cnt;
    logic              s_run;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    skolem_lut_engine #(.NX(NX), .NY(NY), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_data(cfg_data), .cfg_done(cfg_done), .in_valid(in_valid),
        .in_ready(in_ready), .in_x(in_x), .out_valid(out_valid),
        .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .eval_cnt(eval_cnt), .run(run)
    );

    skolem_lut_engine #(.NX(NX), .NY(NY), .CW(CWS)) dut_small (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_data(cfg_data), .cfg_done(cfg_done), .in_valid(in_valid),
        .in_ready(s_in_ready), .in_x(in_x), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_x(s_out_x), .out_y(s_out_y),
        .eval_cnt(s_eval_cnt), .run(s_run)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected counter value for n handshakes at a given width
    function automatic logic [31:0] cnt_exp(input int n, input int w);
        return c_CNT_EN ? 32'(n % (1 << w)) : 32'd0;
    endfunction

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0; cfg_done = 1'b0;
        in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("rst_run", 32'(run), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_x", 32'(out_x), 32'd0);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_eval_cnt", 32'(eval_cnt), 32'd0);

        // Input offered in LOAD is refused
        in_valid = 1'b1; in_x = 5'd3; out_ready = 1'b1;
        tick(); tick();
        check("load_in_ready", 32'(in_ready), 32'd0);
        check("load_out_valid", 32'(out_valid), 32'd0);
        check("load_run", 32'(run), 32'd0);
        in_valid = 1'b0;

        // Program tables: y0 = x[4], y1 = x[0]
        cfg_we = 1'b1; cfg_idx = 1'b0; cfg_data = 32'hFFFF0000;
        tick();
        cfg_idx = 1'b1; cfg_data = 32'hAAAAAAAA;
        tick();
        cfg_we = 1'b0; cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        check("enter_run", 32'(run), 32'd1);
        check("run_in_ready", 32'(in_ready), 32'd1);

        in_valid = 1'b1; in_x = 5'b10001;
        tick();
        check("x17_valid", 32'(out_valid), 32'd1);
        check("x17_x", 32'(out_x), 32'd17);
        check("x17_y", 32'(out_y), 32'b11);
        in_x = 5'b00010;
        tick();                                  // handshake 1
        check("x2_y", 32'(out_y), 32'b00);
        in_valid = 1'b0;
        tick();                                  // handshake 2
        check("x2_drained", 32'(out_valid), 32'd0);
        check("cnt_2", 32'(eval_cnt), cnt_exp(2, CW));

        // Back-to-back stream, no bubbles
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1; in_x = NX'(i);
            tick();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_x", 32'(out_x), 32'(i));
            check("stream_y", 32'(out_y), 32'({i[0], i[4]}));
        end
        in_valid = 1'b0;
        tick();                                  // 32 stream handshakes, total 34
        check("stream_drained", 32'(out_valid), 32'd0);
        check("cnt_34", 32'(eval_cnt), cnt_exp(34, CW));
        check("cnt_small_34", 32'(s_eval_cnt), cnt_exp(34, CWS));

        // Backpressure
        out_ready = 1'b0; in_valid = 1'b1; in_x = 5'd7;
        tick();
        in_x = 5'd25;
        #1;
        check("bp_in_ready", 32'(in_ready), 32'd0);
        tick(); tick();
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_x_stable", 32'(out_x), 32'd7);
        check("bp_y_stable", 32'(out_y), 32'b10);
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        tick();                                  // handshake 35, x=25 accepted
        check("release_x", 32'(out_x), 32'd25);
        check("release_y", 32'(out_y), 32'b11);
        in_valid = 1'b0;
        tick();                                  // handshake 36
        check("release_drained", 32'(out_valid), 32'd0);

        // Reprogram while running, with a same-cycle accept using the old table
        out_ready = 1'b0;
        cfg_we = 1'b1; cfg_idx = 1'b0; cfg_data = 32'h0;
        in_valid = 1'b1; in_x = 5'b10000;
        tick();
        cfg_we = 1'b0; in_valid = 1'b0;
        check("reprog_old_y", 32'(out_y), 32'b01);
        check("reprog_run", 32'(run), 32'd0);
        tick();
        check("held_in_load", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();                                  // handshake 37
        check("held_consumed", 32'(out_valid), 32'd0);
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        in_valid = 1'b1; in_x = 5'b10000;
        tick();
        in_valid = 1'b0;
        check("reprog_new_y", 32'(out_y), 32'b00);
        tick();                                  // handshake 38
        check("cnt_38", 32'(eval_cnt), cnt_exp(38, CW));

        // Asynchronous reset with an output pending
        out_ready = 1'b0; in_valid = 1'b1; in_x = 5'd3;
        tick();
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_cnt", 32'(eval_cnt), 32'd0);
        check("async_rst_run", 32'(run), 32'd0);
        tick();
        rst_n = 1'b1;

        // Tables cleared by reset; then 17 handshakes to wrap the 4-bit counter
        out_ready = 1'b1; cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        in_valid = 1'b1; in_x = 5'd31;
        tick();
        check("cleared_y", 32'(out_y), 32'b00);
        for (int i = 0; i < 16; i++) begin
            in_x = NX'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();                                  // 17 handshakes since reset
        check("cnt_17", 32'(eval_cnt), cnt_exp(17, CW));
        check("cnt_small_wrap", 32'(s_eval_cnt), cnt_exp(17, CWS));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
